pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-generation program-counter block for the pipelined MIPS fetch stage.
//  Extends the plain PC register with these features:
//    - hazard stall and branch/jump redirect, with a pending-redirect buffer
//    - exception vectoring with EPC capture
//    - halt/resume
//    - a boot state that gates the first fetch
//  Sits between hazard/branch logic (ID/EX) and instruction memory (IF).
// PARAMETERS
//  N             32            PC / address width
//  RESET_VECTOR  'h00400000    PC value loaded on reset
//  EXC_VECTOR    'h80000180    PC loaded on exception
//  INC           4             sequential increment, power of 2 (byte step)
// PORTS
//  clk              in   1   clock, all state updates on posedge
//  reset            in   1   asynchronous, active-high reset
//  stall            in   1   hazard unit: hold PC this cycle
//  redirect_valid   in   1   branch/jump taken
//  redirect_target  in   N   branch/jump target address
//  exc_valid        in   1   exception raised by pipeline
//  halt_req         in   1   stop fetching (e.g. exit syscall)
//  resume           in   1   leave HALT
//  pc               out  N   current fetch address
//  pc_plus_inc      out  N   pc+INC, combinational, wraps mod 2^N
//  pc_valid         out  1   pc is a legal fetch this cycle
//  epc              out  N   PC of the excepting fetch
//  halted           out  1   state==HALT
// BEHAVIOUR
//  Reset (async, asserted while reset=1):
//    pc=RESET_VECTOR, epc=0, pending cleared, state=BOOT, pc_valid=0, halted=0.
//  FSM states: BOOT, RUN, HALT. State is registered; pc_valid=(state==RUN).
//  BOOT:
//    - exactly one cycle; all inputs ignored; pc holds; next state RUN.
//    - First valid fetch is at the 2nd posedge after reset deassertion.
//  RUN, priority evaluated at each posedge:
//    1. exc_valid:
//         epc<=pc; pc<=EXC_VECTOR; pending cleared.
//         Overrides stall, redirect and halt_req.
//    2. halt_req:
//         state<=HALT; pc holds; a simultaneous redirect_valid is latched
//         into pending.
//    3. stall:
//         pc holds; if redirect_valid, latch target into pending.
//         A newer redirect overwrites an older pending one.
//    4. redirect_valid:
//         pc<=redirect_target; pending cleared (live redirect beats stale).
//    5. pending valid:
//         pc<=pending target; pending cleared.
//    6. else:
//         pc<=pc+INC, wrapping from 2^N-INC to 0 with no flag.
//  HALT:
//    - pc holds; pc_valid=0.
//    - redirect_valid is latched into pending.
//    - exc_valid: as rule 1, and state<=RUN.
//    - resume (no exc): state<=RUN; pc unchanged on that edge;
//      pending is consumed on the first RUN cycle per the priorities above.
//    - halt_req is ignored while in HALT.
//  Alignment: the low log2(INC) bits of redirect_target are forced to 0 on
//    load. EXC_VECTOR and RESET_VECTOR are used unmodified.
//  Reset mid-operation: immediate async return to the reset values;
//    pending is lost.
//  epc changes only on an accepted exception.
// STRUCTURE
//  Package pc_seq_pkg holds:
//    - state enum {BOOT,RUN,HALT}
//    - default RESET_VECTOR, EXC_VECTOR and INC constants
//    - ALIGN_BITS = $clog2(INC)
//  Sub-module pc_redirect_latch (N): 1-entry pending buffer.
//    Inputs: set/target, clr. Outputs: valid/target.
//    Set wins over clr when both are asserted in the same cycle.
//  Top level contains the FSM, the priority next-PC mux, and the pc/epc
//  registers.
// TESTING
//  1. Reset release, no other inputs:
//       pc=00400000, pc_valid=0 for 1 cycle;
//       then 00400000 (valid), 00400004, 00400008.
//  2. At pc=00400010, stall=1 for 2 cycles with redirect 00400100 in the 1st:
//       pc holds 00400010 during the stall, then 00400100 (from pending).
//  3. Simultaneous exc_valid, stall and redirect at pc=00400020:
//       next pc=80000180, epc=00400020, pending empty afterwards.
//  4. Stall + redirect 00400200, then a live redirect 00400300 the next cycle:
//       pc=00400300; pending discarded.
//  5. halt_req at pc=00400040, then redirect 00400500 while halted,
//     then resume:
//       halted=1 and pc_valid=0 while halted; pc=00400040 on the resume edge;
//       00400500 on the next edge.
//  6. N=8, RESET_VECTOR=FC, INC=4:
//       FC then 00 (wrap).
//     redirect_target=0x13:
//       loads 0x10.
//     reset asserted mid-stall:
//       immediately FC, BOOT.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the fetch-stage program counter.
// Holds the sequencer state encoding and the default vectors/increment.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam int          DEF_INC          = 4;
    localparam int          ALIGN_BITS       = $clog2(DEF_INC);

    // Mask that clears the byte-offset bits below one fetch step.
    function automatic logic [31:0] align_mask32(input int inc);
        logic [31:0] v_mask;
        v_mask = '1;
        for (int i = 0; i < 32; i++) begin
            if (i < $clog2(inc)) v_mask[i] = 1'b0;
        end
        return v_mask;
    endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// One-entry buffer holding a branch/jump target that could not be taken yet.
// Updates on the clock edge; a set in the same cycle as a clear keeps the new target.
module pc_redirect_latch
    import pc_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_set,
    input  logic [N-1:0] i_target,
    input  logic         i_clr,
    output logic         o_valid,
    output logic [N-1:0] o_target
);

    logic         r_valid;
    logic [N-1:0] r_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end else if (i_set) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end else if (i_clr) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC: boot gating, stall/redirect with a pending buffer, exceptions, halt.
// New PC visible one cycle after the deciding edge; stall/halt hold the PC in place.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = N'(DEF_RESET_VECTOR),
    parameter logic [N-1:0] EXC_VECTOR   = N'(DEF_EXC_VECTOR),
    parameter int           INC          = DEF_INC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    input  logic         exc_valid,
    input  logic         halt_req,
    input  logic         resume,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus_inc,
    output logic         pc_valid,
    output logic [N-1:0] epc,
    output logic         halted
);

    localparam logic [N-1:0] LP_INC        = N'(INC);
    localparam logic [N-1:0] LP_ALIGN_MASK = N'(align_mask32(INC));

    pc_state_e    r_state;
    pc_state_e    w_state_nxt;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_epc;
    logic [N-1:0] w_pc_nxt;
    logic [N-1:0] w_epc_nxt;
    logic [N-1:0] w_pc_plus;
    logic [N-1:0] w_tgt_aligned;
    logic         w_pend_set;
    logic         w_pend_clr;
    logic         w_pend_vld;
    logic [N-1:0] w_pend_tgt;

    assign w_pc_plus     = r_pc + LP_INC;
    assign w_tgt_aligned = redirect_target & LP_ALIGN_MASK;

    pc_redirect_latch #(
        .N(N)
    ) u_pending (
        .clk      (clk),
        .rst      (reset),
        .i_set    (w_pend_set),
        .i_target (w_tgt_aligned),
        .i_clr    (w_pend_clr),
        .o_valid  (w_pend_vld),
        .o_target (w_pend_tgt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
        end
    end

    // Exceptions outrank everything; in HALT they also restart fetching.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (exc_valid) begin
                    w_epc_nxt  = r_pc;
                    w_pc_nxt   = EXC_VECTOR;
                    w_pend_clr = 1'b1;
                end else if (halt_req) begin
                    w_state_nxt = ST_HALT;
                    w_pend_set  = redirect_valid;
                end else if (stall) begin
                    w_pend_set = redirect_valid;
                end else if (redirect_valid) begin
                    w_pc_nxt   = w_tgt_aligned;
                    w_pend_clr = 1'b1;
                end else if (w_pend_vld) begin
                    w_pc_nxt   = w_pend_tgt;
                    w_pend_clr = 1'b1;
                end else begin
                    w_pc_nxt = w_pc_plus;
                end
            end
            ST_HALT: begin
                if (exc_valid) begin
                    w_state_nxt = ST_RUN;
                    w_epc_nxt   = r_pc;
                    w_pc_nxt    = EXC_VECTOR;
                    w_pend_clr  = 1'b1;
                end else begin
                    w_pend_set = redirect_valid;
                    if (resume) w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign pc          = r_pc;
    assign pc_plus_inc = w_pc_plus;
    assign pc_valid    = (r_state == ST_RUN);
    assign epc         = r_epc;
    assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a reference model.
// A 32-bit instance is model-checked every cycle; an 8-bit instance covers wrap and alignment.
module tb_pc_sequencer;

    localparam logic [31:0] RV  = 32'h0040_0000;
    localparam logic [31:0] EXV = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, redirect_valid = 1'b0, exc_valid = 1'b0;
    logic        halt_req = 1'b0, resume = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc, pc_plus_inc, epc;
    logic        pc_valid, halted;

    logic        rst8 = 1'b1;
    logic        stall8 = 1'b0, rv8 = 1'b0, exc8 = 1'b0, halt8 = 1'b0, res8 = 1'b0;
    logic [7:0]  rt8 = '0;
    logic [7:0]  pc8, ppi8, epc8;
    logic        pv8, h8;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .exc_valid(exc_valid), .halt_req(halt_req),
        .resume(resume), .pc(pc), .pc_plus_inc(pc_plus_inc), .pc_valid(pc_valid),
        .epc(epc), .halted(halted)
    );

    pc_sequencer #(.N(8), .RESET_VECTOR(8'hFC), .EXC_VECTOR(8'h80), .INC(4)) dut8 (
        .clk(clk), .reset(rst8), .stall(stall8), .redirect_valid(rv8),
        .redirect_target(rt8), .exc_valid(exc8), .halt_req(halt8),
        .resume(res8), .pc(pc8), .pc_plus_inc(ppi8), .pc_valid(pv8),
        .epc(epc8), .halted(h8)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: fetch address advances as a plain byte counter; queued redirect kept in a queue.
    bit          m_boot = 1'b1;
    bit          m_halt = 1'b0;
    logic [31:0] m_pc   = RV;
    logic [31:0] m_epc  = '0;
    logic [31:0] m_pend[$];

    task automatic model_step();
        logic [31:0] tgt;
        tgt = {redirect_target[31:2], 2'b00};
        if (reset) begin
            m_boot = 1'b1; m_halt = 1'b0; m_pc = RV; m_epc = '0; m_pend.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (exc_valid) begin
            m_epc = m_pc; m_pc = EXV; m_pend.delete(); m_halt = 1'b0;
        end else if (m_halt) begin
            if (redirect_valid) begin m_pend.delete(); m_pend.push_back(tgt); end
            if (resume) m_halt = 1'b0;
        end else if (halt_req || stall) begin
            if (redirect_valid) begin m_pend.delete(); m_pend.push_back(tgt); end
            if (halt_req) m_halt = 1'b1;
        end else if (redirect_valid) begin
            m_pc = tgt; m_pend.delete();
        end else if (m_pend.size() > 0) begin
            m_pc = m_pend.pop_front();
        end else begin
            m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("model_pc", pc, m_pc);
            check("model_pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
            check("model_pc_valid", pc_valid, !m_boot && !m_halt);
            check("model_epc", epc, m_epc);
            check("model_halted", halted, m_halt);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        stall = 0; redirect_valid = 0; exc_valid = 0; halt_req = 0; resume = 0;
    endtask

    initial begin
        step(); step();
        cmp_en = 1'b1;
        check("rst_pc", pc, RV);
        check("rst_valid", pc_valid, 1'b0);
        check("rst_epc", epc, 32'h0);
        check("rst_halted", halted, 1'b0);
        reset = 1'b0;
        check("boot_pc", pc, RV);
        check("boot_valid", pc_valid, 1'b0);
        step(); check("first_fetch_pc", pc, 32'h0040_0000); check("first_valid", pc_valid, 1'b1);
        step(); check("seq_pc_4", pc, 32'h0040_0004);
        step(); check("seq_pc_8", pc, 32'h0040_0008);
        step(); step(); check("at_10", pc, 32'h0040_0010);

        stall = 1; redirect_valid = 1; redirect_target = 32'h0040_0100;
        step(); check("stall_hold1", pc, 32'h0040_0010);
        redirect_valid = 0;
        step(); check("stall_hold2", pc, 32'h0040_0010);
        idle();
        step(); check("pending_taken", pc, 32'h0040_0100);

        redirect_valid = 1; redirect_target = 32'h0040_0020;
        step(); check("at_20", pc, 32'h0040_0020);
        exc_valid = 1; stall = 1; redirect_target = 32'h0040_0700;
        step(); check("exc_pc", pc, 32'h8000_0180); check("exc_epc", epc, 32'h0040_0020);
        idle();
        step(); check("exc_no_pending", pc, 32'h8000_0184);

        stall = 1; redirect_valid = 1; redirect_target = 32'h0040_0200;
        step(); check("stall2_hold", pc, 32'h8000_0184);
        stall = 0; redirect_target = 32'h0040_0300;
        step(); check("live_redirect", pc, 32'h0040_0300);
        idle();
        step(); check("stale_discarded", pc, 32'h0040_0304);

        redirect_valid = 1; redirect_target = 32'h0040_0040;
        step(); idle(); halt_req = 1;
        step(); check("halt_flag", halted, 1'b1); check("halt_invalid", pc_valid, 1'b0);
        check("halt_pc", pc, 32'h0040_0040);
        halt_req = 0; redirect_valid = 1; redirect_target = 32'h0040_0500;
        step(); check("halt_hold", pc, 32'h0040_0040); check("halt_still", halted, 1'b1);
        redirect_valid = 0; resume = 1;
        step(); check("resume_pc", pc, 32'h0040_0040); check("resume_valid", pc_valid, 1'b1);
        idle();
        step(); check("resume_pending", pc, 32'h0040_0500);

        redirect_valid = 1; redirect_target = 32'h0040_0613;
        step(); check("align32", pc, 32'h0040_0610);
        idle();

        // Narrow instance: wrap, alignment, asynchronous reset.
        rst8 = 1'b0;
        check("n8_boot_pc", pc8, 8'hFC); check("n8_boot_valid", pv8, 1'b0);
        step(); check("n8_first", pc8, 8'hFC); check("n8_first_valid", pv8, 1'b1);
        check("n8_plus_wrap", ppi8, 8'h00);
        step(); check("n8_wrap", pc8, 8'h00);
        rv8 = 1; rt8 = 8'h13;
        step(); check("n8_align", pc8, 8'h10);
        rv8 = 0; stall8 = 1;
        step(); check("n8_stall", pc8, 8'h10);
        #1 rst8 = 1'b1;
        #1 check("n8_async_pc", pc8, 8'hFC); check("n8_async_valid", pv8, 1'b0);
        check("n8_async_halted", h8, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step();
            if (reset) reset = 1'b0;
            else reset = ($urandom_range(0, 299) == 0);
            exc_valid       = ($urandom_range(0, 24) == 0);
            halt_req        = ($urandom_range(0, 19) == 0);
            stall           = ($urandom_range(0, 4) == 0);
            redirect_valid  = ($urandom_range(0, 3) == 0);
            resume          = ($urandom_range(0, 3) == 0);
            redirect_target = $urandom;
        end
        idle();
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
